// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared bus command encoding and I/O address map for the
//           mem_cmd/mem_addr RAM + I/O bus.
// Revision: 1.0  initial release
// ============================================================================
package mem_pkg;

    // Bus command encoding, shared with the CPU side of the bus
    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_t;

    // Memory-mapped I/O locations (addr[8]=1 region)
    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_dma_copy.sv
`default_nettype none
// ============================================================================
// Module  : mem_dma_copy
// Purpose : Bus initiator copying a block of words from one address range to
//           another, three bus cycles per word (read address, read data,
//           write) once the bus has been granted.
// Revision: 1.0  initial release
// ============================================================================
module mem_dma_copy
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_RD_ADDR = 3'd2;
    localparam logic [2:0] S_RD_DATA = 3'd3;
    localparam logic [2:0] S_WR      = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic [ADDR_W-1:0] remaining;

    // Sequencer; every bus output is loaded together with the state it
    // belongs to, so outputs are pure registers with no decode behind them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            src_cur   <= '0;
            dst_cur   <= '0;
            remaining <= '0;
            bus_req   <= 1'b0;
            mem_cmd   <= MNONE;
            mem_addr  <= '0;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src_cur   <= src_addr;
                        dst_cur   <= dst_addr;
                        remaining <= len;
                        count     <= '0;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            // Nothing to move: skip the bus entirely
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            bus_req <= 1'b1;
                            mem_cmd <= MNONE;
                        end
                    end
                end

                S_REQ: begin
                    if (bus_grant) begin
                        state    <= S_RD_ADDR;
                        mem_cmd  <= MREAD;
                        mem_addr <= src_cur;
                    end
                end

                S_RD_ADDR: begin
                    // RAM registers the address at this edge; data next cycle
                    state <= S_RD_DATA;
                end

                S_RD_DATA: begin
                    out      <= in;
                    state    <= S_WR;
                    mem_cmd  <= MWRITE;
                    mem_addr <= dst_cur;
                end

                S_WR: begin
                    // Write commits at this edge; advance to the next word
                    src_cur   <= src_cur + ONE;
                    dst_cur   <= dst_cur + ONE;
                    count     <= count + ONE;
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        state   <= S_FIN;
                        mem_cmd <= MNONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                    end else if (bus_grant) begin
                        state    <= S_RD_ADDR;
                        mem_cmd  <= MREAD;
                        mem_addr <= src_cur + ONE;
                    end else begin
                        // Bus taken away at a word boundary: re-arbitrate
                        state   <= S_REQ;
                        mem_cmd <= MNONE;
                    end
                end

                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    bus_req <= 1'b0;
                    mem_cmd <= MNONE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_dma_copy
`default_nettype wire
